// File: rtl/cp0_ctrl.sv
// MIPS-style coprocessor 0: exception state, Count/Compare timer
// and interrupt request generation for the exception stage.
module cp0_ctrl #(
  parameter int COUNT_DIV  = 2,
  parameter int HW_INT_NUM = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mtc0_en,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic                  int_req,
  output logic [31:0]           epc_out,
  output logic                  status_exl
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

  logic [31:0]   badvaddr;
  logic [31:0]   count;
  logic [31:0]   compare;
  logic [31:0]   epc;
  logic [PW-1:0] presc;
  logic [7:0]    im;
  logic          exl;
  logic          ie;
  logic          bd;
  logic          ti;
  logic [5:0]    ip_hw;
  logic [1:0]    ip_sw;
  logic [4:0]    exccode;

  logic [5:0]    hw6;
  logic          tick;
  logic          wr_cnt;
  logic          wr_cmp;
  logic          wr_sr;
  logic          wr_cause;
  logic          wr_epc;
  logic [31:0]   status;
  logic [31:0]   cause;

  assign hw6  = 6'(hw_int);
  assign tick = (presc == PMAX);

  // Exceptions own Status/Cause/EPC this cycle; ERET owns Status.
  assign wr_cnt   = mtc0_en && mtc0_addr == 5'd9;
  assign wr_cmp   = mtc0_en && mtc0_addr == 5'd11;
  assign wr_sr    = mtc0_en && mtc0_addr == 5'd12
                    && !exc_valid && !eret;
  assign wr_cause = mtc0_en && mtc0_addr == 5'd13
                    && !exc_valid;
  assign wr_epc   = mtc0_en && mtc0_addr == 5'd14
                    && !exc_valid;

  assign status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign cause  = {bd, ti, 14'b0, ip_hw, ip_sw,
                   1'b0, exccode, 2'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      epc      <= '0;
      presc    <= '0;
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ti       <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      exccode  <= '0;
    end else begin
      if (wr_cnt) begin
        count <= mtc0_wdata;
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) count <= count + 32'd1;
      end

      if (wr_cmp) begin
        compare <= mtc0_wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end

      ip_hw <= {ti | hw6[5], hw6[4:0]};

      if (exc_valid) begin
        if (!exl) begin
          epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          bd  <= exc_bd;
        end
        exl     <= 1'b1;
        exccode <= exc_code;
        if (exc_code == 5'd4 || exc_code == 5'd5)
          badvaddr <= exc_badvaddr;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (wr_sr) begin
        exl <= mtc0_wdata[1];
      end

      if (wr_sr) begin
        im <= mtc0_wdata[15:8];
        ie <= mtc0_wdata[0];
      end
      if (wr_cause) ip_sw <= mtc0_wdata[9:8];
      if (wr_epc) epc <= mtc0_wdata;
    end
  end

  always_comb begin
    case (mfc0_addr)
      5'd8:    mfc0_rdata = badvaddr;
      5'd9:    mfc0_rdata = count;
      5'd11:   mfc0_rdata = compare;
      5'd12:   mfc0_rdata = status;
      5'd13:   mfc0_rdata = cause;
      5'd14:   mfc0_rdata = epc;
      default: mfc0_rdata = '0;
    endcase
  end

  assign int_req    = ie & ~exl & |({ip_hw, ip_sw} & im);
  assign epc_out    = epc;
  assign status_exl = exl;

endmodule
